// File: rtl/tpu_arb_pkg.sv
// tpu_arb_pkg: shared definitions for the TPU bus arbiter.
//   - arb_state_e : arbiter FSM states (ARB, C_LOCK, MUL_WAIT)
//   - address map constants for the A/B/C buffers, the multiply trigger
//     and the idle bus address
//   - err_code_e  : protocol error classes raised by the optional checker
package tpu_arb_pkg;

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    C_LOCK   = 2'd1,
    MUL_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSPLIT  = 2'd1,
    ERR_VDROP   = 2'd2,
    ERR_CORPHAN = 2'd3
  } err_code_e;

  localparam logic [15:0] A_BASE    = 16'h0100;
  localparam logic [15:0] A_LIMIT   = 16'h013F;
  localparam logic [15:0] B_BASE    = 16'h0200;
  localparam logic [15:0] B_LIMIT   = 16'h023F;
  localparam logic [15:0] C_BASE    = 16'h0300;
  localparam logic [15:0] C_LIMIT   = 16'h037F;
  localparam logic [15:0] MUL_ADDR  = 16'h0400;
  localparam logic [15:0] IDLE_ADDR = 16'h0000;

endpackage

// File: rtl/tpu_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   [N-1:0]  : request vector
//   ptr   [IW-1:0] : highest-priority index this cycle
//   grant [N-1:0]  : one-hot winner (all zero when no request)
//   idx   [IW-1:0] : binary index of the winner (0 when no request)
module rr_pick #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [N-1:0] upper;
  logic [N-1:0] pool;

  // Requests at or above ptr win first; if none, wrap to the lowest request.
  always_comb begin
    upper = req & ({N{1'b1}} << ptr);
    pool  = (|upper) ? upper : req;
    grant = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pool[i] && (grant == '0)) begin
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/tpu_bus_arbiter.sv
// tpu_bus_arbiter: round-robin arbiter of NREQ host requesters onto the TPU
// memory-mapped bus, keeping two-beat C writes atomic and blocking the bus
// for the systolic multiply latency (3*DIM-2 cycles) after a MUL trigger.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester beat handshake (ready = issued now)
//   req_rw/addr/wdata : per-requester beat contents
//   rsp_valid/rdata   : read response, one cycle after the read issues
//   tpu_r_w/addr/dataIn, tpu_dataOut : TPU bus
//   mul_busy          : multiply in flight
//   err               : sticky protocol error
// Optional feature: define TPU_ARB_CHECK_EN to build the protocol checker;
// otherwise err is tied low.
module tpu_bus_arbiter
  import tpu_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned ADDRW = 16,
  parameter int unsigned DATAW = 64,
  parameter int unsigned DIM   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0]             req_rw,
  input  logic [NREQ-1:0][ADDRW-1:0]  req_addr,
  input  logic [NREQ-1:0][DATAW-1:0]  req_wdata,
  output logic [NREQ-1:0]             rsp_valid,
  output logic [DATAW-1:0]            rsp_rdata,
  output logic                        tpu_r_w,
  output logic [ADDRW-1:0]            tpu_addr,
  output logic [DATAW-1:0]            tpu_dataIn,
  input  logic [DATAW-1:0]            tpu_dataOut,
  output logic                        mul_busy,
  output logic                        err
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = ($clog2(3 * DIM - 2) < 1) ? 1 : $clog2(3 * DIM - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(3 * DIM - 3);

  function automatic logic is_c_addr(input logic [ADDRW-1:0] a);
    return (a >= ADDRW'(C_BASE)) && (a <= ADDRW'(C_LIMIT));
  endfunction

  arb_state_e       state_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    lock_id_q;
  logic [CW-1:0]    cnt_q;
  logic [NREQ-1:0]  rsp_valid_q;
  logic [DATAW-1:0] rsp_rdata_q;

  logic [NREQ-1:0]  pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             hi_ok;
  logic             issue;
  logic [IW-1:0]    sel;

  rr_pick #(.N(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Grant decode. Only the locked requester's C high beat may issue in C_LOCK.
  always_comb begin
    hi_ok = req_valid[lock_id_q] && req_rw[lock_id_q] &&
            is_c_addr(req_addr[lock_id_q]) && req_addr[lock_id_q][3];
    issue     = 1'b0;
    sel       = pick_idx;
    req_ready = '0;
    if (!rst) begin
      unique case (state_q)
        ARB: begin
          if (|pick_grant) begin
            issue     = 1'b1;
            sel       = pick_idx;
            req_ready = pick_grant;
          end
        end
        C_LOCK: begin
          if (hi_ok) begin
            issue              = 1'b1;
            sel                = lock_id_q;
            req_ready[lock_id_q] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tpu_r_w    = issue & req_rw[sel];
  assign tpu_addr   = issue ? req_addr[sel]  : ADDRW'(IDLE_ADDR);
  assign tpu_dataIn = issue ? req_wdata[sel] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      lock_id_q   <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (issue && !req_rw[sel]) begin
        rsp_valid_q[sel] <= 1'b1;
        rsp_rdata_q      <= tpu_dataOut;
      end
      unique case (state_q)
        ARB: begin
          if (issue) begin
            ptr_q <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
            if (req_rw[pick_idx] && is_c_addr(req_addr[pick_idx]) &&
                !req_addr[pick_idx][3]) begin
              state_q   <= C_LOCK;
              lock_id_q <= pick_idx;
            end else if (req_rw[pick_idx] &&
                         (req_addr[pick_idx] == ADDRW'(MUL_ADDR))) begin
              state_q <= MUL_WAIT;
              cnt_q   <= '0;
            end
          end
        end
        // Either the high beat issued or the slot is abandoned; both end here.
        C_LOCK: state_q <= ARB;
        MUL_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ARB;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mul_busy  = (state_q == MUL_WAIT);

`ifdef TPU_ARB_CHECK_EN
  err_code_e       err_code;
  logic [NREQ-1:0] vld_q;
  logic [NREQ-1:0] rdy_q;
  logic            err_q;

  // A valid that was pending (valid, not ready) last cycle must not vanish.
  always_comb begin
    err_code = ERR_NONE;
    if ((state_q == C_LOCK) && !hi_ok && !rst) begin
      err_code = ERR_CSPLIT;
    end else if (|(vld_q & ~rdy_q & ~req_valid)) begin
      err_code = ERR_VDROP;
    end else if ((state_q == ARB) && issue && req_rw[sel] &&
                 is_c_addr(req_addr[sel]) && req_addr[sel][3]) begin
      err_code = ERR_CORPHAN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      rdy_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= req_valid;
      rdy_q <= req_ready;
      if (err_code != ERR_NONE) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_bus_arbiter.sv
// Directed testbench for tpu_bus_arbiter (NREQ=2, ADDRW=16, DATAW=64, DIM=8).
module tb_tpu_bus_arbiter;

`ifdef TPU_ARB_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  localparam logic [63:0] WD0 = 64'hA0A0_0000_0000_00A0;
  localparam logic [63:0] WD1 = 64'hB1B1_0000_0000_00B1;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_rw;
  logic [1:0][15:0] req_addr;
  logic [1:0][63:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [63:0]      rsp_rdata;
  logic             tpu_r_w;
  logic [15:0]      tpu_addr;
  logic [63:0]      tpu_dataIn;
  logic [63:0]      tpu_dataOut;
  logic             mul_busy;
  logic             err;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  tpu_bus_arbiter #(
    .NREQ  (2),
    .ADDRW (16),
    .DATAW (64),
    .DIM   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rw      (req_rw),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .tpu_r_w     (tpu_r_w),
    .tpu_addr    (tpu_addr),
    .tpu_dataIn  (tpu_dataIn),
    .tpu_dataOut (tpu_dataOut),
    .mul_busy    (mul_busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  rw;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [1:0]  exp_rdy;
    logic [1:0]  exp_rsp;
    logic        exp_rw;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic [1:0] v, input logic [1:0] rw,
                       input logic [15:0] a0, input logic [15:0] a1);
    @(negedge clk);
    req_valid   = v;
    req_rw      = rw;
    req_addr[0] = a0;
    req_addr[1] = a1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [63:0] exp_din;

  initial begin
    rst          = 1'b1;
    req_valid    = 2'b00;
    req_rw       = 2'b00;
    req_addr[0]  = 16'h0;
    req_addr[1]  = 16'h0;
    req_wdata[0] = WD0;
    req_wdata[1] = WD1;
    tpu_dataOut  = 64'h0;

    //            v      rw     a0        a1        rdy    rsp    rw    addr
    tbl[0]  = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0, 16'h0000};
    tbl[1]  = '{2'b11, 2'b11, 16'h0100, 16'h0200, 2'b01, 2'b00, 1'b1, 16'h0100};
    tbl[2]  = '{2'b11, 2'b11, 16'h0100, 16'h0200, 2'b10, 2'b00, 1'b1, 16'h0200};
    tbl[3]  = '{2'b11, 2'b11, 16'h0100, 16'h0200, 2'b01, 2'b00, 1'b1, 16'h0100};
    tbl[4]  = '{2'b11, 2'b11, 16'h0100, 16'h0200, 2'b10, 2'b00, 1'b1, 16'h0200};
    tbl[5]  = '{2'b01, 2'b00, 16'h0110, 16'h0000, 2'b01, 2'b00, 1'b0, 16'h0110};
    tbl[6]  = '{2'b01, 2'b01, 16'h0120, 16'h0000, 2'b01, 2'b01, 1'b1, 16'h0120};
    tbl[7]  = '{2'b10, 2'b10, 16'h0000, 16'h0500, 2'b10, 2'b00, 1'b1, 16'h0500};
    tbl[8]  = '{2'b11, 2'b00, 16'h0210, 16'h0220, 2'b01, 2'b00, 1'b0, 16'h0210};
    tbl[9]  = '{2'b11, 2'b11, 16'h0130, 16'h0230, 2'b10, 2'b01, 1'b1, 16'h0230};
    tbl[10] = '{2'b01, 2'b00, 16'h0300, 16'h0000, 2'b01, 2'b00, 1'b0, 16'h0300};
    tbl[11] = '{2'b10, 2'b10, 16'h0000, 16'h0308, 2'b10, 2'b01, 1'b1, 16'h0308};

    // Reset state
    do_reset();
    #1;
    chk("reset_ready",    {62'd0, req_ready}, 64'd0);
    chk("reset_rsp",      {62'd0, rsp_valid}, 64'd0);
    chk("reset_rdata",    rsp_rdata, 64'd0);
    chk("reset_addr",     {48'd0, tpu_addr}, 64'd0);
    chk("reset_rw",       {63'd0, tpu_r_w}, 64'd0);
    chk("reset_din",      tpu_dataIn, 64'd0);
    chk("reset_mulbusy",  {63'd0, mul_busy}, 64'd0);
    chk("reset_err",      {63'd0, err}, 64'd0);

    // Table: round-robin alternation, reads, unmapped write, C read, orphan C high beat
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].rw, tbl[i].a0, tbl[i].a1);
      exp_din = (tbl[i].exp_rdy == 2'b01) ? WD0 :
                (tbl[i].exp_rdy == 2'b10) ? WD1 : 64'd0;
      chk($sformatf("tbl%0d_ready", i), {62'd0, req_ready}, {62'd0, tbl[i].exp_rdy});
      chk($sformatf("tbl%0d_rsp", i),   {62'd0, rsp_valid}, {62'd0, tbl[i].exp_rsp});
      chk($sformatf("tbl%0d_rw", i),    {63'd0, tpu_r_w},   {63'd0, tbl[i].exp_rw});
      chk($sformatf("tbl%0d_addr", i),  {48'd0, tpu_addr},  {48'd0, tbl[i].exp_addr});
      chk($sformatf("tbl%0d_din", i),   tpu_dataIn, exp_din);
      chk($sformatf("tbl%0d_busy", i),  {63'd0, mul_busy}, 64'd0);
      chk($sformatf("tbl%0d_err", i),   {63'd0, err}, 64'd0);
    end
    drive(2'b00, 2'b00, 16'h0, 16'h0);
    chk("orphan_err", {63'd0, err}, {63'd0, CHK});

    // C two-beat write from req1 while req0 waits
    do_reset();
    drive(2'b01, 2'b01, 16'h0100, 16'h0000);
    chk("cl_pre_ready", {62'd0, req_ready}, 64'd1);
    drive(2'b11, 2'b11, 16'h0100, 16'h0300);
    chk("cl_lo_ready", {62'd0, req_ready}, 64'd2);
    chk("cl_lo_addr",  {48'd0, tpu_addr}, 64'h0300);
    drive(2'b11, 2'b11, 16'h0100, 16'h0308);
    chk("cl_hi_ready", {62'd0, req_ready}, 64'd2);
    chk("cl_hi_addr",  {48'd0, tpu_addr}, 64'h0308);
    chk("cl_hi_din",   tpu_dataIn, WD1);
    drive(2'b01, 2'b01, 16'h0100, 16'h0000);
    chk("cl_after_ready", {62'd0, req_ready}, 64'd1);
    chk("cl_after_addr",  {48'd0, tpu_addr}, 64'h0100);
    chk("cl_err",         {63'd0, err}, 64'd0);

    // Multiply blackout
    do_reset();
    tpu_dataOut = 64'h5555_6666_7777_8888;
    drive(2'b01, 2'b01, 16'h0400, 16'h0000);
    chk("mul_issue_ready", {62'd0, req_ready}, 64'd1);
    chk("mul_issue_addr",  {48'd0, tpu_addr}, 64'h0400);
    chk("mul_issue_busy",  {63'd0, mul_busy}, 64'd0);
    for (int k = 1; k <= 22; k++) begin
      drive(2'b10, 2'b00, 16'h0000, 16'h0230);
      chk($sformatf("mul_t%0d_busy", k),  {63'd0, mul_busy}, 64'd1);
      chk($sformatf("mul_t%0d_ready", k), {62'd0, req_ready}, 64'd0);
      chk($sformatf("mul_t%0d_addr", k),  {48'd0, tpu_addr}, 64'd0);
    end
    drive(2'b10, 2'b00, 16'h0000, 16'h0230);
    chk("mul_end_busy",  {63'd0, mul_busy}, 64'd0);
    chk("mul_end_ready", {62'd0, req_ready}, 64'd2);
    chk("mul_end_addr",  {48'd0, tpu_addr}, 64'h0230);
    chk("mul_end_rw",    {63'd0, tpu_r_w}, 64'd0);
    drive(2'b00, 2'b00, 16'h0000, 16'h0000);
    chk("mul_rsp_valid", {62'd0, rsp_valid}, 64'd2);
    chk("mul_rsp_rdata", rsp_rdata, 64'h5555_6666_7777_8888);

    // Read response latency
    do_reset();
    tpu_dataOut = 64'h1111_2222_3333_4444;
    drive(2'b01, 2'b00, 16'h0300, 16'h0000);
    chk("rd_ready", {62'd0, req_ready}, 64'd1);
    chk("rd_rsp_same_cycle", {62'd0, rsp_valid}, 64'd0);
    drive(2'b00, 2'b00, 16'h0000, 16'h0000);
    tpu_dataOut = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("rd_rsp_valid", {62'd0, rsp_valid}, 64'd1);
    chk("rd_rsp_rdata", rsp_rdata, 64'h1111_2222_3333_4444);
    chk("rd_bus_idle",  {48'd0, tpu_addr}, 64'd0);
    drive(2'b00, 2'b00, 16'h0000, 16'h0000);
    chk("rd_rsp_clear", {62'd0, rsp_valid}, 64'd0);

    // C low beat without a high beat
    do_reset();
    drive(2'b01, 2'b01, 16'h0300, 16'h0000);
    chk("cs_lo_ready", {62'd0, req_ready}, 64'd1);
    drive(2'b00, 2'b00, 16'h0000, 16'h0000);
    chk("cs_abort_ready", {62'd0, req_ready}, 64'd0);
    chk("cs_abort_addr",  {48'd0, tpu_addr}, 64'd0);
    chk("cs_abort_rw",    {63'd0, tpu_r_w}, 64'd0);
    chk("cs_abort_din",   tpu_dataIn, 64'd0);
    drive(2'b01, 2'b00, 16'h0100, 16'h0000);
    chk("cs_back_ready", {62'd0, req_ready}, 64'd1);
    chk("cs_err",        {63'd0, err}, {63'd0, CHK});

    // Reset in the middle of a multiply blackout
    do_reset();
    drive(2'b01, 2'b01, 16'h0400, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      drive(2'b00, 2'b00, 16'h0000, 16'h0000);
      chk($sformatf("rm_busy%0d", k), {63'd0, mul_busy}, 64'd1);
    end
    @(negedge clk);
    rst         = 1'b1;
    req_valid   = 2'b11;
    req_rw      = 2'b11;
    req_addr[0] = 16'h0100;
    req_addr[1] = 16'h0200;
    #1;
    chk("rm_in_reset_ready", {62'd0, req_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rm_busy_cleared", {63'd0, mul_busy}, 64'd0);
    chk("rm_err",          {63'd0, err}, 64'd0);
    chk("rm_rsp",          {62'd0, rsp_valid}, 64'd0);
    chk("rm_first_ready",  {62'd0, req_ready}, 64'd1);
    chk("rm_first_addr",   {48'd0, tpu_addr}, 64'h0100);
    drive(2'b11, 2'b11, 16'h0100, 16'h0200);
    chk("rm_second_ready", {62'd0, req_ready}, 64'd2);

    drive(2'b00, 2'b00, 16'h0000, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
